carryless_poly_reducer: RTL and testbench
=========================================

// Module: carryless_poly_reducer
//
// PURPOSE
//   Reduces a 2*DATA_WIDTH-bit carryless product modulo x^DATA_WIDTH + polynomial_i.
//   Sits directly downstream of the carryless multipliers: it consumes their {high, low}
//   product halves and returns the GF(2^DATA_WIDTH) field element.
//   The reduction is iterative (MSB-first long division), so the block trades latency for area.
//   Valid/ready handshake on both input and output.
//
// PARAMETERS
//   DATA_WIDTH      32  width of each product half, the polynomial and the remainder
//   BITS_PER_CYCLE  1   division steps per clock; must divide DATA_WIDTH
//
// PORTS
//   clk_i            in   1           clock; all state updates on the rising edge
//   rst_i            in   1           asynchronous, active-high reset
//   valid_i          in   1           input operands valid
//   ready_o          out  1           block can accept an operation
//   product_high_i   in   DATA_WIDTH  upper half of the carryless product
//   product_low_i    in   DATA_WIDTH  lower half of the carryless product
//   polynomial_i     in   DATA_WIDTH  low DATA_WIDTH coefficients; x^DATA_WIDTH term implicit
//   valid_o          out  1           remainder_o valid
//   ready_i          in   1           downstream accepts the result
//   remainder_o      out  DATA_WIDTH  ({high,low}) mod (x^DATA_WIDTH + polynomial_i)
//
// BEHAVIOUR
//   - Reset (async, rst_i=1):
//     - state = IDLE, valid_o = 0, remainder_o = 0, step counter = 0.
//     - R, L and P registers are cleared.
//     - Aborts any in-flight operation, with no output produced.
//   - FSM states:
//     - IDLE -> REDUCE on valid_i & ready_o.
//     - REDUCE -> DONE when the counter reaches DATA_WIDTH/BITS_PER_CYCLE - 1.
//     - DONE -> IDLE on ready_i with no new valid_i.
//     - DONE -> REDUCE on ready_i & valid_i (back-to-back operation).
//   - ready_o = (state==IDLE) | (state==DONE & ready_i). This is a combinational path from ready_i.
//   - Accept: registers R <= product_high_i, L <= product_low_i, P <= polynomial_i.
//     Inputs are sampled only on the accept cycle.
//   - One division step:
//     - t = R[MSB]
//     - R = {R[DATA_WIDTH-2:0], L[MSB]}
//     - L = L << 1
//     - if t, R ^= P
//     - BITS_PER_CYCLE steps are chained combinationally each REDUCE cycle.
//   - After DATA_WIDTH steps, R holds the remainder. remainder_o = R, and valid_o = 1 only in DONE.
//   - Latency:
//     - Accept at cycle 0.
//     - valid_o is first seen high at cycle DATA_WIDTH/BITS_PER_CYCLE + 1.
//     - Throughput is one result per DATA_WIDTH/BITS_PER_CYCLE + 1 cycles.
//   - Backpressure: while valid_o & !ready_i, remainder_o and valid_o are held stable, and no
//     input is accepted.
//   - Boundary cases:
//     - product_high_i = 0: result equals product_low_i.
//     - polynomial_i = 0: reduction is modulo x^N, so the result equals product_low_i.
//     - All-ones operands must be handled with no overflow.
//   - valid_i while REDUCE is ignored, because ready_o is 0. The upstream must hold the operands.
//
// TESTING
//   (DATA_WIDTH=8 unless noted)
//   1. AES field: high=0x2B, low=0x79, poly=0x1B, BPC=1 -> valid_o at cycle 9, remainder_o=0xC1.
//   2. Passthrough: high=0x00, low=0xA5, poly=0x1B -> remainder_o=0xA5 after full latency.
//   3. BITS_PER_CYCLE=8: repeat test 1 -> valid_o at cycle 2, remainder_o=0xC1.
//   4. Backpressure:
//      - Stimulus: hold ready_i=0 for 5 cycles in DONE.
//      - Response: remainder_o and valid_o stable, ready_o=0.
//      - Then raise ready_i with valid_i=1 -> new operand accepted in the same cycle.
//   5. Reset mid-REDUCE (cycle 4 of test 1):
//      - valid_o=0 and remainder_o=0 asynchronously, ready_o=1 after release.
//      - Next operation completes correctly.
//   6. DATA_WIDTH=32, random: 1000 operands with BPC in {1,4,32}, checked against a reference
//      model of the product mod (x^32 + poly).

Source files
------------

// File: rtl/carryless_poly_reducer.sv
// Reduces a {high, low} carryless product modulo x^DATA_WIDTH + polynomial_i using
// iterative MSB-first long division, BITS_PER_CYCLE steps per clock.
module carryless_poly_reducer #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] product_high_i,
    input  logic [DATA_WIDTH-1:0] product_low_i,
    input  logic [DATA_WIDTH-1:0] polynomial_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] remainder_o
);

    localparam int STEPS = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    // IDLE: waiting for operands | REDUCE: division steps running | DONE: result held until taken
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic [DATA_WIDTH-1:0] l_q, l_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;
    logic [DATA_WIDTH-1:0] r_step, l_step;
    logic                  fb;
    logic                  accept;

    always_comb begin
        r_step = r_q;
        l_step = l_q;
        fb     = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            fb     = r_step[DATA_WIDTH-1];
            r_step = {r_step[DATA_WIDTH-2:0], l_step[DATA_WIDTH-1]} ^ (fb ? p_q : '0);
            l_step = {l_step[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign ready_o     = (state_q == IDLE) | ((state_q == DONE) & ready_i);
    assign accept      = valid_i & ready_o;
    assign valid_o     = (state_q == DONE);
    assign remainder_o = r_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        l_d     = l_q;
        p_d     = p_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    r_d     = product_high_i;
                    l_d     = product_low_i;
                    p_d     = polynomial_i;
                    cnt_d   = '0;
                    state_d = REDUCE;
                end else if (state_q == DONE && ready_i) begin
                    state_d = IDLE;
                end
            end
            REDUCE: begin
                r_d = r_step;
                l_d = l_step;
                if (cnt_q == CW'(STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            l_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            l_q     <= l_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: tb/tb_carryless_poly_reducer.sv
// Directed and random checks of carryless_poly_reducer: 8-bit instances (BPC 1, 8)
// and 32-bit instances (BPC 1, 4, 32) sharing inputs within each width group.
module tb_carryless_poly_reducer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_valid_i = 1'b0, a_ready_i = 1'b1;
    logic [7:0] a_high = '0, a_low = '0, a_poly = '0;
    logic       a1_ready_o, a1_valid_o, a8_ready_o, a8_valid_o;
    logic [7:0] a1_rem, a8_rem;

    logic        b_valid_i = 1'b0, b_ready_i = 1'b1;
    logic [31:0] b_high = '0, b_low = '0, b_poly = '0;
    logic        b1_ready_o, b1_valid_o, b4_ready_o, b4_valid_o, b32_ready_o, b32_valid_o;
    logic [31:0] b1_rem, b4_rem, b32_rem;

    carryless_poly_reducer #(.DATA_WIDTH(8), .BITS_PER_CYCLE(1)) u_a1 (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a1_ready_o),
        .product_high_i(a_high), .product_low_i(a_low), .polynomial_i(a_poly),
        .valid_o(a1_valid_o), .ready_i(a_ready_i), .remainder_o(a1_rem));
    carryless_poly_reducer #(.DATA_WIDTH(8), .BITS_PER_CYCLE(8)) u_a8 (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a8_ready_o),
        .product_high_i(a_high), .product_low_i(a_low), .polynomial_i(a_poly),
        .valid_o(a8_valid_o), .ready_i(a_ready_i), .remainder_o(a8_rem));
    carryless_poly_reducer #(.DATA_WIDTH(32), .BITS_PER_CYCLE(1)) u_b1 (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b1_ready_o),
        .product_high_i(b_high), .product_low_i(b_low), .polynomial_i(b_poly),
        .valid_o(b1_valid_o), .ready_i(b_ready_i), .remainder_o(b1_rem));
    carryless_poly_reducer #(.DATA_WIDTH(32), .BITS_PER_CYCLE(4)) u_b4 (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b4_ready_o),
        .product_high_i(b_high), .product_low_i(b_low), .polynomial_i(b_poly),
        .valid_o(b4_valid_o), .ready_i(b_ready_i), .remainder_o(b4_rem));
    carryless_poly_reducer #(.DATA_WIDTH(32), .BITS_PER_CYCLE(32)) u_b32 (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b32_ready_o),
        .product_high_i(b_high), .product_low_i(b_low), .polynomial_i(b_poly),
        .valid_o(b32_valid_o), .ready_i(b_ready_i), .remainder_o(b32_rem));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Textbook long division on the full 64-bit product, top degree downwards.
    function automatic logic [31:0] ref_mod(input logic [31:0] h, input logic [31:0] l,
                                            input logic [31:0] p);
        logic [63:0] v;
        logic [63:0] g;
        v = {h, l};
        g = {31'd0, 1'b1, p};
        for (int i = 63; i >= 32; i--)
            if (v[i]) v = v ^ (g << (i - 32));
        return v[31:0];
    endfunction

    // Counts negedges after the accept edge until each 8-bit instance shows valid_o.
    task automatic wait_a(output logic [7:0] r1, output logic [7:0] r8,
                          output int lat1, output int lat8);
        lat1 = -1; lat8 = -1; r1 = '0; r8 = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (a1_valid_o && lat1 < 0) begin lat1 = c; r1 = a1_rem; end
            if (a8_valid_o && lat8 < 0) begin lat8 = c; r8 = a8_rem; end
            if (lat1 >= 0 && lat8 >= 0) break;
        end
    endtask

    task automatic run_a(input logic [7:0] h, input logic [7:0] l, input logic [7:0] p,
                         output logic [7:0] r1, output logic [7:0] r8,
                         output int lat1, output int lat8);
        @(negedge clk);
        a_high = h; a_low = l; a_poly = p;
        a_valid_i = 1'b1; a_ready_i = 1'b1;
        @(posedge clk);
        #1 a_valid_i = 1'b0;
        wait_a(r1, r8, lat1, lat8);
    endtask

    task automatic run_b(input logic [31:0] h, input logic [31:0] l, input logic [31:0] p,
                         input int idx);
        logic [31:0] exp, r1, r4, r32;
        int lat1, lat4, lat32;
        exp = ref_mod(h, l, p);
        lat1 = -1; lat4 = -1; lat32 = -1; r1 = '0; r4 = '0; r32 = '0;
        @(negedge clk);
        b_high = h; b_low = l; b_poly = p;
        b_valid_i = 1'b1; b_ready_i = 1'b1;
        @(posedge clk);
        #1 b_valid_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (b1_valid_o && lat1 < 0) begin lat1 = c; r1 = b1_rem; end
            if (b4_valid_o && lat4 < 0) begin lat4 = c; r4 = b4_rem; end
            if (b32_valid_o && lat32 < 0) begin lat32 = c; r32 = b32_rem; end
            if (lat1 >= 0 && lat4 >= 0 && lat32 >= 0) break;
        end
        chk($sformatf("rand%0d_rem_bpc1", idx), 64'(r1), 64'(exp));
        chk($sformatf("rand%0d_rem_bpc4", idx), 64'(r4), 64'(exp));
        chk($sformatf("rand%0d_rem_bpc32", idx), 64'(r32), 64'(exp));
        chk($sformatf("rand%0d_lat_bpc1", idx), 64'(lat1), 64'd33);
        chk($sformatf("rand%0d_lat_bpc4", idx), 64'(lat4), 64'd9);
        chk($sformatf("rand%0d_lat_bpc32", idx), 64'(lat32), 64'd2);
    endtask

    typedef struct {
        logic [7:0] high;
        logic [7:0] low;
        logic [7:0] poly;
        logic [7:0] rem;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] r1, r8;
        int lat1, lat8;
        int seen;

        vecs[0] = '{8'h2B, 8'h79, 8'h1B, 8'hC1};  // AES field example
        vecs[1] = '{8'h00, 8'hA5, 8'h1B, 8'hA5};  // high half zero
        vecs[2] = '{8'h2B, 8'h79, 8'h00, 8'h79};  // modulo x^8
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};  // all ones
        vecs[4] = '{8'hFF, 8'hFF, 8'h1B, 8'h35};
        vecs[5] = '{8'h01, 8'h00, 8'h1B, 8'h1B};  // x^8
        vecs[6] = '{8'h80, 8'h00, 8'h1B, 8'h2F};  // x^15

        #1;
        chk("reset_valid_a1", 64'(a1_valid_o), 64'd0);
        chk("reset_rem_a1", 64'(a1_rem), 64'd0);
        chk("reset_ready_a1", 64'(a1_ready_o), 64'd1);
        chk("reset_ready_a8", 64'(a8_ready_o), 64'd1);
        chk("reset_valid_b1", 64'(b1_valid_o), 64'd0);
        chk("reset_ready_b1", 64'(b1_ready_o), 64'd1);
        chk("reset_ready_b4", 64'(b4_ready_o), 64'd1);
        chk("reset_ready_b32", 64'(b32_ready_o), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_a(vecs[i].high, vecs[i].low, vecs[i].poly, r1, r8, lat1, lat8);
            chk($sformatf("vec%0d_rem_bpc1", i), 64'(r1), 64'(vecs[i].rem));
            chk($sformatf("vec%0d_rem_bpc8", i), 64'(r8), 64'(vecs[i].rem));
            chk($sformatf("vec%0d_lat_bpc1", i), 64'(lat1), 64'd9);
            chk($sformatf("vec%0d_lat_bpc8", i), 64'(lat8), 64'd2);
        end

        // Backpressure in DONE, then back-to-back accept as ready_i rises.
        @(negedge clk);
        a_high = 8'h2B; a_low = 8'h79; a_poly = 8'h1B;
        a_valid_i = 1'b1; a_ready_i = 1'b0;
        @(posedge clk);
        #1 a_valid_i = 1'b0;
        wait_a(r1, r8, lat1, lat8);
        chk("bp_lat_bpc1", 64'(lat1), 64'd9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), 64'(a1_valid_o), 64'd1);
            chk($sformatf("bp%0d_rem", k), 64'(a1_rem), 64'hC1);
            chk($sformatf("bp%0d_ready", k), 64'(a1_ready_o), 64'd0);
            chk($sformatf("bp%0d_valid_bpc8", k), 64'(a8_valid_o), 64'd1);
        end
        a_high = 8'h80; a_low = 8'h00; a_poly = 8'h1B;
        a_valid_i = 1'b1; a_ready_i = 1'b1;
        #1;
        chk("b2b_ready_comb", 64'(a1_ready_o), 64'd1);
        @(posedge clk);
        #1 a_valid_i = 1'b0;
        wait_a(r1, r8, lat1, lat8);
        chk("b2b_rem_bpc1", 64'(r1), 64'h2F);
        chk("b2b_lat_bpc1", 64'(lat1), 64'd9);
        chk("b2b_rem_bpc8", 64'(r8), 64'h2F);
        chk("b2b_lat_bpc8", 64'(lat8), 64'd2);

        // Asynchronous reset four cycles into a reduction.
        @(negedge clk);
        a_high = 8'h2B; a_low = 8'h79; a_poly = 8'h1B;
        a_valid_i = 1'b1; a_ready_i = 1'b1;
        @(posedge clk);
        #1 a_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 64'(a1_valid_o), 64'd0);
        chk("abort_rem", 64'(a1_rem), 64'd0);
        chk("abort_rem_bpc8", 64'(a8_rem), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 64'(a1_ready_o), 64'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (a1_valid_o) seen++;
        end
        chk("abort_no_output", 64'(seen), 64'd0);
        run_a(8'h2B, 8'h79, 8'h1B, r1, r8, lat1, lat8);
        chk("post_abort_rem", 64'(r1), 64'hC1);
        chk("post_abort_lat", 64'(lat1), 64'd9);

        // 32-bit reference-model comparison, corners first.
        run_b(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_b(32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1);
        run_b(32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_008D, 2);
        for (int i = 3; i < 1000; i++)
            run_b($urandom, $urandom, $urandom, i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
